// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM generator sharing one period counter.
// Settings are double-buffered and applied only at a period boundary.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_run               1 = counting, 0 = counter held at 0, outputs idle
//   i_period            staged terminal count
//   i_duty              staged compare values, channel i at [i*CNT_W +: CNT_W]
//   i_center_mode       staged mode: 0 = edge-aligned, 1 = center-aligned
//   i_polarity          staged per-channel polarity (1 = active-low)
//   i_ch_en             staged per-channel enable
//   i_update            one-cycle strobe capturing all staged inputs
//   o_pwm               registered PWM outputs
//   o_period_tick       pulse in the first cycle of each period
//   o_update_ack        pulse in the first cycle running new settings
//   o_pending           a captured update waits for the next boundary
module pwm_multi_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run,
    input  logic [CNT_W-1:0]          i_period,
    input  logic [CHANNELS*CNT_W-1:0] i_duty,
    input  logic                      i_center_mode,
    input  logic [CHANNELS-1:0]       i_polarity,
    input  logic [CHANNELS-1:0]       i_ch_en,
    input  logic                      i_update,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_period_tick,
    output logic                      o_update_ack,
    output logic                      o_pending
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Counter state
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_dir_up;

    // Active settings
    logic [CNT_W-1:0]          r_per;
    logic [CHANNELS*CNT_W-1:0] r_duty;
    logic                      r_center;
    logic [CHANNELS-1:0]       r_pol;
    logic [CHANNELS-1:0]       r_en;

    // Staged settings
    logic [CNT_W-1:0]          r_stg_per;
    logic [CHANNELS*CNT_W-1:0] r_stg_duty;
    logic                      r_stg_center;
    logic [CHANNELS-1:0]       r_stg_pol;
    logic [CHANNELS-1:0]       r_stg_en;
    logic                      r_pending;

    // Registered outputs
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_tick;
    logic                      r_ack;

    logic                      w_top;
    logic                      w_bound;
    logic                      w_load;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_dir_nxt;
    logic [CHANNELS-1:0]       w_raw;
    logic [CHANNELS-1:0]       w_pwm_nxt;

    assign w_top = (r_cnt == r_per);

    // Center mode ends on the down-count cnt==1; with P==1 there is no down
    // phase, so the top (cnt==1, still counting up) is the boundary instead.
    always_comb begin
        w_bound = 1'b1;
        if (i_run) begin
            if (r_center) begin
                w_bound = (r_per == '0) ||
                          ((r_cnt == ONE) && (!r_dir_up || (r_per == ONE)));
            end else begin
                w_bound = w_top;
            end
        end
    end

    // An update strobe in the boundary cycle loads directly, bypassing staging.
    assign w_load = w_bound && (r_pending || i_update);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir_up;
        if (w_bound) begin
            w_cnt_nxt = '0;
            w_dir_nxt = 1'b1;
        end else if (!r_center) begin
            w_cnt_nxt = r_cnt + ONE;
        end else if (r_dir_up) begin
            if (w_top) begin
                w_cnt_nxt = r_cnt - ONE;
                w_dir_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt - ONE;
        end
    end

    // Disabled channels sit at their polarity level; enabled ones flip it
    // while the counter is below the duty value.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_raw[i] = (r_cnt < r_duty[i*CNT_W +: CNT_W]);
        end
        w_pwm_nxt = i_run ? (r_pol ^ (w_raw & r_en)) : r_pol;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_dir_up     <= 1'b1;
            r_per        <= '0;
            r_duty       <= '0;
            r_center     <= 1'b0;
            r_pol        <= '0;
            r_en         <= '0;
            r_stg_per    <= '0;
            r_stg_duty   <= '0;
            r_stg_center <= 1'b0;
            r_stg_pol    <= '0;
            r_stg_en     <= '0;
            r_pending    <= 1'b0;
            r_pwm        <= '0;
            r_tick       <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_nxt;
            r_pwm    <= w_pwm_nxt;
            r_tick   <= i_run && w_bound;
            r_ack    <= w_load;
            if (w_load) begin
                if (i_update) begin
                    r_per    <= i_period;
                    r_duty   <= i_duty;
                    r_center <= i_center_mode;
                    r_pol    <= i_polarity;
                    r_en     <= i_ch_en;
                end else begin
                    r_per    <= r_stg_per;
                    r_duty   <= r_stg_duty;
                    r_center <= r_stg_center;
                    r_pol    <= r_stg_pol;
                    r_en     <= r_stg_en;
                end
                r_pending <= 1'b0;
            end else if (i_update) begin
                r_stg_per    <= i_period;
                r_stg_duty   <= i_duty;
                r_stg_center <= i_center_mode;
                r_stg_pol    <= i_polarity;
                r_stg_en     <= i_ch_en;
                r_pending    <= 1'b1;
            end
        end
    end

    assign o_pwm         = r_pwm;
    assign o_period_tick = r_tick;
    assign o_update_ack  = r_ack;
    assign o_pending     = r_pending;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: table-driven, directed and random checks of pwm_multi_gen
// against a period-phase reference model (CHANNELS=2, CNT_W=8).
module tb_pwm_multi_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  period = '0;
    logic [15:0] duty = '0;
    logic        center_mode = 1'b0;
    logic [1:0]  polarity = '0;
    logic [1:0]  ch_en = '0;
    logic        update = 1'b0;
    logic [1:0]  pwm;
    logic        period_tick;
    logic        update_ack;
    logic        pending;

    int n_pass = 0;
    int n_total = 0;

    pwm_multi_gen #(
        .CHANNELS (2),
        .CNT_W    (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_run         (run),
        .i_period      (period),
        .i_duty        (duty),
        .i_center_mode (center_mode),
        .i_polarity    (polarity),
        .i_ch_en       (ch_en),
        .i_update      (update),
        .o_pwm         (pwm),
        .o_period_tick (period_tick),
        .o_update_ack  (update_ack),
        .o_pending     (pending)
    );

    always #5 clk = ~clk;

    // Reference model: phase index k within the period, config sets.
    int         m_k;
    int         m_per;
    int         m_duty [2];
    bit         m_ctr;
    bit   [1:0] m_pol;
    bit   [1:0] m_en;
    int         s_per;
    int         s_duty [2];
    bit         s_ctr;
    bit   [1:0] s_pol;
    bit   [1:0] s_en;
    bit         m_pending;
    bit   [1:0] e_pwm;
    bit         e_tick;
    bit         e_ack;

    task automatic m_reset();
        m_k = 0; m_per = 0; m_ctr = 0; m_pol = '0; m_en = '0;
        s_per = 0; s_ctr = 0; s_pol = '0; s_en = '0; m_pending = 0;
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 0;
            s_duty[i] = 0;
        end
        e_pwm = '0; e_tick = 0; e_ack = 0;
    endtask

    function automatic int m_len();
        if (m_ctr) return (m_per == 0) ? 1 : 2 * m_per;
        return m_per + 1;
    endfunction

    function automatic int m_cnt();
        if (m_ctr && m_k > m_per) return 2 * m_per - m_k;
        return m_k;
    endfunction

    // Advance the model across one clock edge using the inputs seen there.
    task automatic m_edge();
        int  c;
        bit  bound;
        bit  load;
        c     = m_cnt();
        bound = !run || (m_k == m_len() - 1);
        for (int i = 0; i < 2; i++) begin
            if (!run || !m_en[i]) e_pwm[i] = m_pol[i];
            else e_pwm[i] = m_pol[i] ^ (c < m_duty[i]);
        end
        load   = bound && (m_pending || update);
        e_tick = run && bound;
        e_ack  = load;
        if (load) begin
            if (update) begin
                m_per = int'(period); m_ctr = center_mode; m_pol = polarity; m_en = ch_en;
                m_duty[0] = int'(duty[7:0]); m_duty[1] = int'(duty[15:8]);
            end else begin
                m_per = s_per; m_ctr = s_ctr; m_pol = s_pol; m_en = s_en;
                m_duty[0] = s_duty[0]; m_duty[1] = s_duty[1];
            end
            m_pending = 0;
        end else if (update) begin
            s_per = int'(period); s_ctr = center_mode; s_pol = polarity; s_en = ch_en;
            s_duty[0] = int'(duty[7:0]); s_duty[1] = int'(duty[15:8]);
            m_pending = 1;
        end
        m_k = bound ? 0 : m_k + 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m_edge();
        chk("pwm", int'(pwm), int'(e_pwm));
        chk("period_tick", int'(period_tick), int'(e_tick));
        chk("update_ack", int'(update_ack), int'(e_ack));
        chk("pending", int'(pending), int'(m_pending));
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = update_ack;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = update_ack;
        end
        chk(name, int'(got), 1);
    endtask

    task automatic set_cfg(input int per, input int d0, input int d1, input bit ctr,
                           input bit [1:0] pol, input bit [1:0] en);
        period      = 8'(per);
        duty        = {8'(d1), 8'(d0)};
        center_mode = ctr;
        polarity    = pol;
        ch_en       = en;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    // Counts high cycles of each pwm and ticks over n cycles.
    task automatic measure(input int n, output int hi0, output int hi1, output int ticks,
                           output int acks);
        hi0 = 0; hi1 = 0; ticks = 0; acks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            hi0   += int'(pwm[0]);
            hi1   += int'(pwm[1]);
            ticks += int'(period_tick);
            acks  += int'(update_ack);
        end
    endtask

    typedef struct {
        int       per;
        int       d0;
        int       d1;
        bit       ctr;
        bit [1:0] pol;
        bit [1:0] en;
        int       win;
        int       hi0;
        int       hi1;
        int       ticks;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int hi0, hi1, ticks, acks;
        int guard;

        // per d0 d1 ctr pol en | window hi0 hi1 ticks (window = two periods)
        vecs[0] = '{9, 3, 10, 1'b0, 2'b00, 2'b11, 20, 6, 20, 2};
        vecs[1] = '{4, 2, 0, 1'b1, 2'b00, 2'b11, 16, 6, 0, 2};
        vecs[2] = '{0, 1, 0, 1'b0, 2'b00, 2'b11, 2, 2, 0, 2};
        vecs[3] = '{1, 1, 2, 1'b1, 2'b00, 2'b11, 4, 2, 4, 2};
        vecs[4] = '{9, 3, 0, 1'b0, 2'b01, 2'b01, 20, 14, 0, 2};
        vecs[5] = '{5, 2, 2, 1'b0, 2'b10, 2'b00, 12, 0, 12, 2};
        vecs[6] = '{3, 4, 3, 1'b1, 2'b00, 2'b11, 12, 12, 10, 2};

        m_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_tick", int'(period_tick), 0);
        chk("reset_ack", int'(update_ack), 0);
        chk("reset_pending", int'(pending), 0);
        #9 rst_n = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Table-driven configurations
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].per, vecs[v].d0, vecs[v].d1, vecs[v].ctr, vecs[v].pol, vecs[v].en);
            pulse_update();
            wait_ack($sformatf("vec%0d_ack", v));
            measure(vecs[v].win, hi0, hi1, ticks, acks);
            chk($sformatf("vec%0d_hi0", v), hi0, vecs[v].hi0);
            chk($sformatf("vec%0d_hi1", v), hi1, vecs[v].hi1);
            chk($sformatf("vec%0d_ticks", v), ticks, vecs[v].ticks);
        end

        // Mid-period update is held until the boundary
        set_cfg(9, 3, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        wait_ack("pend_base_ack");
        guard = 0;
        while (m_k != 4 && guard < 50) begin step(); guard++; end
        set_cfg(9, 7, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        chk("pend_set", int'(pending), 1);
        wait_ack("pend_ack");
        chk("pend_tick_with_ack", int'(period_tick), 1);
        chk("pend_clear", int'(pending), 0);
        measure(10, hi0, hi1, ticks, acks);
        chk("pend_width7", hi0, 7);

        // Two updates within one period give one ack; the last one wins
        set_cfg(9, 5, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        step();
        set_cfg(9, 8, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        wait_ack("dbl_ack");
        measure(10, hi0, hi1, ticks, acks);
        chk("dbl_width8", hi0, 8);
        chk("dbl_no_extra_ack", acks, 0);

        // Polarity, enable and run=0
        set_cfg(9, 3, 0, 1'b0, 2'b01, 2'b00);
        pulse_update();
        wait_ack("pol_ack");
        measure(10, hi0, hi1, ticks, acks);
        chk("pol_idle_high", hi0, 10);
        set_cfg(9, 3, 0, 1'b0, 2'b01, 2'b01);
        pulse_update();
        wait_ack("pol_en_ack");
        measure(10, hi0, hi1, ticks, acks);
        chk("pol_low3", hi0, 7);
        run = 1'b0;
        measure(5, hi0, hi1, ticks, acks);
        chk("stop_idle", hi0, 5);
        chk("stop_no_tick", ticks, 0);
        run = 1'b1;

        // Asynchronous reset with a pending update
        set_cfg(9, 5, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        wait_ack("rst_base_ack");
        guard = 0;
        while (m_k != 2 && guard < 50) begin step(); guard++; end
        set_cfg(9, 2, 0, 1'b0, 2'b00, 2'b01);
        pulse_update();
        chk("rst_pre_pwm0", int'(pwm[0]), 1);
        chk("rst_pre_pending", int'(pending), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pwm", int'(pwm), 0);
        chk("rst_async_pending", int'(pending), 0);
        m_reset();
        #3 rst_n = 1'b1;
        measure(20, hi0, hi1, ticks, acks);
        chk("rst_after_pwm0", hi0, 0);
        chk("rst_after_pwm1", hi1, 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_cfg($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 15),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)));
                update = 1'b1;
            end else begin
                update = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) run = ~run;
            step();
        end
        update = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
